// File: rtl/puf_challenge_gen.sv
// PUF challenge generator: Fibonacci XNOR LFSR stepped by a ready/valid consumer,
// with seeded runs of a programmable length, period-wrap detection and lockup-seed rejection.
module puf_challenge_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_dv,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] num_chal,
  input  logic             chal_ready,
  output logic [WIDTH-1:0] chal_out,
  output logic             chal_valid,
  output logic             busy,
  output logic             done,
  output logic             period_wrap,
  output logic             lockup_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Maximal-length XNOR taps; tap n maps to state bit n-1.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      TAP_MASK = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~^(v & TAP_MASK[WIDTH-1:0])};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] remaining;

  logic             seed_acc;
  logic             seed_ok;
  logic             lock_nxt;
  logic             start_acc;
  logic             handshake;
  logic [WIDTH-1:0] s_adv;
  logic [WIDTH-1:0] s_start;

  // A seed accepted in the same cycle as start takes effect before the run begins,
  // including its effect on the lockup flag.
  always_comb begin
    seed_acc  = en & seed_dv;
    seed_ok   = (seed != ALL_ONES);
    lock_nxt  = seed_acc ? ~seed_ok : lockup_err;
    start_acc = en & start & (num_chal != '0) & ~lock_nxt;
    s_start   = (seed_acc & seed_ok) ? seed : s;
    handshake = chal_valid & chal_ready;
    s_adv     = lfsr_step(s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s           <= '0;
      seed_q      <= '0;
      remaining   <= '0;
      lockup_err  <= 1'b0;
      chal_out    <= '0;
      chal_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      done        <= 1'b0;
      period_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_acc) begin
            if (seed_ok) begin
              s      <= seed;
              seed_q <= seed;
            end
            lockup_err <= ~seed_ok;
          end
          if (start_acc) begin
            state      <= RUN;
            remaining  <= num_chal;
            chal_out   <= s_start;
            chal_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            s           <= s_adv;
            period_wrap <= (s_adv == seed_q);
            if (remaining <= CNT_W'(1)) begin
              state      <= DONE;
              remaining  <= '0;
              chal_out   <= '0;
              chal_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              remaining <= remaining - CNT_W'(1);
              chal_out  <= s_adv;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_gen.sv
// Randomized self-checking bench for puf_challenge_gen: a transaction-level model of the
// challenge sequence for WIDTH=8, plus a WIDTH=4 instance for full-period checks.
module tb_puf_challenge_gen;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, seed_dv, start, chal_ready;
  logic [7:0]    seed;
  logic [CW-1:0] num_chal;
  logic [7:0]    chal_out;
  logic          chal_valid, busy, done, period_wrap, lockup_err;

  logic          en4, seed_dv4, start4, chal_ready4;
  logic [3:0]    seed4;
  logic [CW-1:0] num_chal4;
  logic [3:0]    chal_out4;
  logic          chal_valid4, busy4, done4, period_wrap4, lockup_err4;

  always #5 clk = ~clk;

  puf_challenge_gen #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .seed_dv(seed_dv), .seed(seed), .start(start),
    .num_chal(num_chal), .chal_ready(chal_ready), .chal_out(chal_out),
    .chal_valid(chal_valid), .busy(busy), .done(done), .period_wrap(period_wrap),
    .lockup_err(lockup_err)
  );

  puf_challenge_gen #(.WIDTH(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .seed_dv(seed_dv4), .seed(seed4), .start(start4),
    .num_chal(num_chal4), .chal_ready(chal_ready4), .chal_out(chal_out4),
    .chal_valid(chal_valid4), .busy(busy4), .done(done4), .period_wrap(period_wrap4),
    .lockup_err(lockup_err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference state: current LFSR value, stored seed, lockup flag.
  logic [7:0] m_s, m_seed;
  bit         m_lock;
  logic [7:0] obs_q[$];

  // One LFSR step for an 8-bit register: shift left, feedback = NOT(b7 xor b5 xor b4 xor b3).
  function automatic logic [7:0] model_next(input logic [7:0] v);
    int fb;
    fb = 1 - (((v >> 7) + (v >> 5) + (v >> 4) + (v >> 3)) & 1);
    return 8'(((int'(v) * 2) + fb) % 256);
  endfunction

  // Issue one command cycle from IDLE; returns whether the model expects a run to start.
  task automatic cmd(input bit e, input bit sdv, input logic [7:0] sd, input bit st,
                     input int n, output bit started);
    en = e; seed_dv = sdv; seed = sd; start = st; num_chal = n[CW-1:0];
    @(negedge clk);
    en = 1'b1; seed_dv = 1'b0; start = 1'b0;
    if (e && sdv) begin
      if (sd != 8'hFF) begin
        m_s = sd; m_seed = sd; m_lock = 1'b0;
      end else begin
        m_lock = 1'b1;
      end
    end
    started = e && st && (n != 0) && !m_lock;
  endtask

  // mode 0: ready always high; 1: random ready and random command noise; 2: stall for 3 cycles.
  task automatic run(input int n, input int mode);
    int         hs = 0;
    int         cyc = 0;
    bit         exp_wrap = 1'b0;
    bit         rdy;
    logic [7:0] cur;
    while (hs < n) begin
      if (cyc > 40 * n + 100) begin
        check("run_timeout", 64'(hs), 64'(n));
        break;
      end
      if (chal_valid !== 1'b1) begin
        check("run_valid", 64'(chal_valid), 64'd1);
        break;
      end
      check("run_busy", 64'(busy), 64'd1);
      check("run_data", 64'(chal_out), 64'(m_s));
      check("run_wrap", 64'(period_wrap), 64'(exp_wrap));
      check("run_done_low", 64'(done), 64'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(cyc >= 1 && cyc <= 3);
      endcase
      chal_ready = rdy;
      if (mode == 1) begin
        en      = 1'($urandom_range(0, 1));
        seed_dv = 1'($urandom_range(0, 1));
        seed    = 8'($urandom);
        start   = 1'($urandom_range(0, 1));
      end
      cur = chal_out;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        obs_q.push_back(cur);
        hs++;
        m_s      = model_next(m_s);
        exp_wrap = (m_s == m_seed);
      end else begin
        exp_wrap = 1'b0;
        check("stall_hold", 64'(chal_out), 64'(cur));
      end
    end
    chal_ready = 1'b0; en = 1'b1; seed_dv = 1'b0; start = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("done_valid", 64'(chal_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("done_wrap", 64'(period_wrap), 64'(exp_wrap));
    @(negedge clk);
    check("done_once", 64'(done), 64'd0);
  endtask

  logic [7:0] exp42 [5];

  initial begin
    bit         st;
    bit         re, rsdv, rst_cmd;
    logic [7:0] rsd;
    int         rn;
    logic [3:0] v4[$];
    int         wraps, wrap_at, distinct;

    exp42 = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    rst = 1'b1; en = 1'b0; seed_dv = 1'b0; seed = '0; start = 1'b0; num_chal = '0; chal_ready = 1'b0;
    en4 = 1'b0; seed_dv4 = 1'b0; seed4 = '0; start4 = 1'b0; num_chal4 = '0; chal_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 64'(chal_out), 64'd0);
    check("rst_valid", 64'(chal_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wrap", 64'(period_wrap), 64'd0);
    check("rst_lock", 64'(lockup_err), 64'd0);
    check("rst_valid4", 64'(chal_valid4), 64'd0);
    rst = 1'b0; m_s = '0; m_seed = '0; m_lock = 1'b0;
    @(negedge clk);

    // Known sequence from seed 0x00, then continuation across runs.
    cmd(1, 1, 8'h00, 0, 0, st);
    check("seed_only_idle", 64'(busy), 64'd0);
    obs_q.delete();
    cmd(1, 0, 8'h00, 1, 5, st);
    run(5, 0);
    check("seq_len", 64'(obs_q.size()), 64'd5);
    if (obs_q.size() == 5)
      for (int i = 0; i < 5; i++) check("seq_val", 64'(obs_q[i]), 64'(exp42[i]));
    cmd(1, 0, 8'h00, 1, 3, st);
    check("next_start_1e", 64'(chal_out), 64'h1E);
    run(3, 0);

    // Back-pressure mid-run.
    cmd(1, 0, 8'h00, 1, 6, st);
    run(6, 2);

    // Lockup seed rejection and recovery.
    cmd(1, 1, 8'hFF, 0, 0, st);
    check("lock_set", 64'(lockup_err), 64'd1);
    cmd(1, 0, 8'h00, 1, 4, st);
    check("lock_start_busy", 64'(busy), 64'd0);
    check("lock_start_valid", 64'(chal_valid), 64'd0);
    cmd(1, 1, 8'h5A, 0, 0, st);
    check("lock_clr", 64'(lockup_err), 64'd0);
    cmd(1, 0, 8'h00, 1, 3, st);
    check("first_5a", 64'(chal_out), 64'h5A);
    run(3, 1);

    // Commands ignored with en low or zero length.
    cmd(0, 1, 8'h11, 1, 4, st);
    check("en0_ignored", 64'(busy), 64'd0);
    cmd(1, 0, 8'h00, 1, 0, st);
    check("num0_ignored", 64'(busy), 64'd0);

    // Seed and start in the same cycle.
    cmd(1, 1, 8'h3C, 1, 4, st);
    check("same_cycle_3c", 64'(chal_out), 64'h3C);
    run(4, 0);

    // Asynchronous reset in the middle of a run.
    cmd(1, 0, 8'h00, 1, 10, st);
    chal_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(chal_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out", 64'(chal_out), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_wrap", 64'(period_wrap), 64'd0);
    chal_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_s = '0; m_seed = '0; m_lock = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(done), 64'd0);
    end
    obs_q.delete();
    cmd(1, 0, 8'h00, 1, 1, st);
    check("post_rst_first", 64'(chal_out), 64'h00);
    run(1, 0);

    // Randomized command/run mix.
    for (int it = 0; it < 14; it++) begin
      re      = ($urandom_range(0, 3) != 0);
      rsdv    = 1'($urandom_range(0, 1));
      rsd     = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      rst_cmd = ($urandom_range(0, 3) != 0);
      rn      = int'($urandom_range(0, 12));
      cmd(re, rsdv, rsd, rst_cmd, rn, st);
      check("rand_lock", 64'(lockup_err), 64'(m_lock));
      if (st) run(rn, 1);
      else check("rand_idle", 64'(busy), 64'd0);
    end

    // WIDTH=4: full period from seed 0 over a 20-challenge run.
    en4 = 1'b1; seed_dv4 = 1'b1; seed4 = 4'h0; start4 = 1'b1; num_chal4 = 16'd20; chal_ready4 = 1'b1;
    @(negedge clk);
    seed_dv4 = 1'b0; start4 = 1'b0;
    wraps = 0; wrap_at = -1;
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        check("w4_valid", 64'(chal_valid4), 64'd1);
        if (k < 15) v4.push_back(chal_out4);
      end
      if (period_wrap4) begin
        wraps++;
        wrap_at = k;
      end
      if (k == 15) check("w4_return", 64'(chal_out4), 64'(v4[0]));
      if (k < 20) begin
        check("w4_done_low", 64'(done4), 64'd0);
        @(negedge clk);
      end else begin
        check("w4_done", 64'(done4), 64'd1);
      end
    end
    chal_ready4 = 1'b0;
    distinct = 0;
    for (int i = 0; i < v4.size(); i++) begin
      bit dup = 1'b0;
      for (int j = 0; j < i; j++) if (v4[j] == v4[i]) dup = 1'b1;
      if (!dup) distinct++;
    end
    check("w4_distinct", 64'(distinct), 64'd15);
    check("w4_wrap_cnt", 64'(wraps), 64'd1);
    check("w4_wrap_at", 64'(wrap_at), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_gen.md
PUF_CHALLENGE_GEN -- requirements
Module: puf_challenge_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the LFSR/challenge width; the legal range is 3..32.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the challenge-count field.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, which gates acceptance of seed_dv and start.
REQ-006 SHALL have port seed_dv, input, 1 bit, a one-cycle seed-load strobe.
REQ-007 SHALL have port seed, input, WIDTH bits, the seed value.
REQ-008 SHALL have port start, input, 1 bit, a one-cycle run request.
REQ-009 SHALL have port num_chal, input, CNT_W bits, the number of challenges to emit per run.
REQ-010 SHALL have port chal_ready, input, 1 bit, the consumer ready signal.
REQ-011 SHALL have port chal_out, output, WIDTH bits, the current challenge.
REQ-012 SHALL have port chal_valid, output, 1 bit, which marks chal_out as valid.
REQ-013 SHALL have port busy, output, 1 bit, high while the FSM is in RUN.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a run.
REQ-015 SHALL have port period_wrap, output, 1 bit, a one-cycle pulse when the LFSR returns to the stored seed.
REQ-016 SHALL have port lockup_err, output, 1 bit, a sticky flag indicating a rejected lockup seed.

Function
REQ-017 SHALL implement a Fibonacci XNOR LFSR, state s[WIDTH-1:0], next = {s[WIDTH-2:0], fb}, where fb is the XNOR chain of the maximal-length taps for WIDTH (3..32).
REQ-018 SHALL use taps 8,6,5,4 for WIDTH=8, so fb = ~(s7^s5^s4^s3).
REQ-019 SHALL treat the all-ones state as the lockup state.
REQ-020 SHALL implement FSM states IDLE, RUN and DONE, with reset to IDLE.
REQ-021 SHALL, in IDLE with en=1 and seed_dv=1 and seed != all-ones, load s and an internal seed register from seed and clear lockup_err.
REQ-022 SHALL, in IDLE with en=1 and seed_dv=1 and seed == all-ones, leave s and the seed register unchanged and set lockup_err until the next accepted seed load.
REQ-023 SHALL, in IDLE with en=1, start=1 and num_chal != 0, move to RUN next cycle and set the remaining counter to num_chal.
REQ-024 SHALL ignore start when num_chal == 0, when en=0, or when lockup_err=1.
REQ-025 SHALL, when seed_dv and start are accepted in the same cycle, load the seed first so the first challenge equals the new seed.
REQ-026 SHALL, in RUN, drive chal_valid=1, chal_out=s and busy=1.
REQ-027 SHALL, in RUN, hold chal_out stable while chal_valid=1 and chal_ready=0.
REQ-028 SHALL, on a handshake (chal_valid & chal_ready), advance s by one step and decrement remaining.
REQ-029 SHALL, on a handshake with remaining == 1, move to DONE instead.
REQ-030 SHALL not apply back-pressure beyond chal_ready, so a new challenge is offered the cycle after each handshake.
REQ-031 SHALL, in DONE, pulse done=1 with chal_valid=0 and busy=0, then return to IDLE.
REQ-032 SHALL retain s across runs, so the next start continues the sequence.
REQ-033 SHALL ignore seed_dv and start while in RUN or DONE.
REQ-034 SHALL have en affect only command acceptance; a run in progress is not paused by en=0.
REQ-035 SHALL pulse period_wrap for one cycle when an advance produces s equal to the seed register, and continue the run without stopping.
REQ-036 SHALL have a period of 2^WIDTH-1 for every non-lockup seed.
REQ-037 SHALL saturate arithmetic so remaining never underflows, and SHALL not wrap num_chal internally.

Reset
REQ-038 SHALL, on rst, asynchronously force s=0, seed register=0, remaining=0, FSM=IDLE and lockup_err=0.
REQ-039 SHALL, on rst, force chal_out=0, chal_valid=0, busy=0, done=0 and period_wrap=0.
REQ-040 SHALL, when rst is asserted mid-RUN, abort the run immediately with no done pulse.
REQ-041 SHALL accept a run after reset without any seed load, starting from s=0.

Verification
REQ-042 SHALL cover: WIDTH=8, seed 0x00, num_chal=5, chal_ready tied 1 -> chal_out 00,01,03,07,0F on consecutive cycles, then a done pulse, and the next start begins at 0x1E.
REQ-043 SHALL cover: chal_ready low for 3 cycles mid-run -> chal_valid stays 1, chal_out holds its value, and no advance occurs.
REQ-044 SHALL cover: seed 0xFF -> lockup_err=1 and s unchanged, start ignored, then seed 0x5A -> lockup_err clears.
REQ-045 SHALL cover: WIDTH=4, seed 0x0, num_chal=20 -> exactly 15 distinct values, a period_wrap pulse on the 15th advance, and done after 20 handshakes.
REQ-046 SHALL cover: rst asserted during RUN -> outputs go to 0 within the same cycle (asynchronously), no done pulse, and a subsequent start with num_chal=1 emits 0x00.
REQ-047 SHALL cover: seed_dv=1 and start=1 in the same cycle with seed 0x3C -> the first challenge is 0x3C.
